// File: rtl/mem_bus_ctrl_pkg.sv
// Shared architecture constants for the memory bus controller: address map,
// bus widths and UART FSM state encodings.
package mem_bus_ctrl_pkg;

  localparam int unsigned MEM_ADDR_BUS  = 8;
  localparam int unsigned MEM_BUS_WIDTH = 32;

  localparam int unsigned RAM_TOP        = 'hEF;
  localparam int unsigned UART_DATA_ADDR = 'hF0;
  localparam int unsigned UART_STAT_ADDR = 'hF1;
  localparam int unsigned LED_ADDR       = 'hF2;
  localparam int unsigned CYCLE_ADDR     = 'hF3;

  typedef enum logic [1:0] {
    UART_IDLE  = 2'd0,
    UART_START = 2'd1,
    UART_DATA  = 2'd2,
    UART_STOP  = 2'd3
  } uart_state_t;

  // UART_STATUS layout: {count[3:0], ovf, empty, full, busy}
  function automatic logic [7:0] pack_uart_status(input logic busy, input logic full,
                                                  input logic empty, input logic ovf,
                                                  input logic [3:0] count);
    return {count, ovf, empty, full, busy};
  endfunction

endpackage

// File: rtl/uart_tx_fifo.sv
// Byte FIFO feeding an 8N1 UART transmitter; pops one byte per frame while idle.
module uart_tx_fifo
  import mem_bus_ctrl_pkg::*;
#(
  parameter int unsigned CLKS_PER_BIT = 868,
  parameter int unsigned FIFO_DEPTH   = 8
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          push,
  input  logic [7:0]                    push_data,
  output logic                          full,
  output logic                          empty,
  output logic [$clog2(FIFO_DEPTH):0]   count,
  output logic                          busy,
  output logic                          tx
);

  localparam int unsigned PTR_W  = $clog2(FIFO_DEPTH);
  localparam int unsigned CNT_W  = PTR_W + 1;
  localparam int unsigned BAUD_W = $clog2(CLKS_PER_BIT);
  localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);

  logic [7:0]        mem [FIFO_DEPTH];
  logic [PTR_W-1:0]  wr_ptr, rd_ptr;
  logic [BAUD_W-1:0] baud_cnt;
  logic [2:0]        bit_cnt;
  logic [7:0]        shreg;
  logic              do_push, pop, baud_done;
  uart_state_t       state, next_state;

  assign full      = (count == CNT_W'(FIFO_DEPTH));
  assign empty     = (count == '0);
  // A full FIFO drops the push even when a pop frees a slot in the same cycle.
  assign do_push   = push && !full;
  assign baud_done = (baud_cnt == BAUD_LAST);

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)     rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      baud_cnt <= '0;
      bit_cnt  <= '0;
      shreg    <= '0;
    end else begin
      if (state == UART_IDLE || baud_done) baud_cnt <= '0;
      else                                 baud_cnt <= baud_cnt + 1'b1;

      if (state != UART_DATA)  bit_cnt <= '0;
      else if (baud_done)      bit_cnt <= bit_cnt + 1'b1;

      if (pop)                                  shreg <= mem[rd_ptr];
      else if (state == UART_DATA && baud_done) shreg <= shreg >> 1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) state <= UART_IDLE;
    else     state <= next_state;
  end

  always_comb begin
    next_state = state;
    case (state)
      UART_IDLE:  if (!empty)                         next_state = UART_START;
      UART_START: if (baud_done)                      next_state = UART_DATA;
      UART_DATA:  if (baud_done && bit_cnt == 3'd7)   next_state = UART_STOP;
      UART_STOP:  if (baud_done)                      next_state = UART_IDLE;
      default:                                        next_state = UART_IDLE;
    endcase
  end

  always_comb begin
    tx   = 1'b1;
    busy = 1'b1;
    pop  = 1'b0;
    case (state)
      UART_IDLE: begin
        busy = 1'b0;
        pop  = !empty;
      end
      UART_START: tx = 1'b0;
      UART_DATA:  tx = shreg[0];
      UART_STOP:  tx = 1'b1;
      default:    tx = 1'b1;
    endcase
  end

endmodule

// File: rtl/mem_bus_ctrl.sv
// CPU memory bus decoder: 240-word RAM, UART TX with FIFO, LED register and
// free-running cycle counter, with a registered read data port.
module mem_bus_ctrl
  import mem_bus_ctrl_pkg::*;
#(
  parameter int unsigned ADDR_W       = MEM_ADDR_BUS,
  parameter int unsigned DATA_W       = MEM_BUS_WIDTH,
  parameter int unsigned CLKS_PER_BIT = 868,
  parameter int unsigned FIFO_DEPTH   = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              write,
  input  logic              read,
  input  logic [ADDR_W-1:0] address,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] rdata,
  output logic [7:0]        led,
  output logic              uart_tx
);

  localparam int unsigned RAM_WORDS = RAM_TOP + 1;
  localparam int unsigned CNT_W     = $clog2(FIFO_DEPTH) + 1;

  logic [DATA_W-1:0] ram [RAM_WORDS];
  logic [DATA_W-1:0] cycle, rd_mux;
  logic [CNT_W-1:0]  fifo_count;
  logic wr_en, rd_en, is_ram, is_stat, is_led, is_cycle;
  logic fifo_push, fifo_full, fifo_empty, tx_busy, ovf;

  // Write wins over a simultaneous read; both are ignored while in reset.
  assign wr_en     = write && !rst;
  assign rd_en     = read && !write && !rst;
  assign is_ram    = (address <= ADDR_W'(RAM_TOP));
  assign is_stat   = (address == ADDR_W'(UART_STAT_ADDR));
  assign is_led    = (address == ADDR_W'(LED_ADDR));
  assign is_cycle  = (address == ADDR_W'(CYCLE_ADDR));
  assign fifo_push = wr_en && (address == ADDR_W'(UART_DATA_ADDR));

  uart_tx_fifo #(
    .CLKS_PER_BIT (CLKS_PER_BIT),
    .FIFO_DEPTH   (FIFO_DEPTH)
  ) u_uart (
    .clk       (clk),
    .rst       (rst),
    .push      (fifo_push),
    .push_data (wdata[7:0]),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .count     (fifo_count),
    .busy      (tx_busy),
    .tx        (uart_tx)
  );

  // RAM has no reset so its contents survive rst.
  always_ff @(posedge clk) begin
    if (wr_en && is_ram) ram[address] <= wdata;
  end

  always_comb begin
    rd_mux = '0;
    if (is_ram)        rd_mux = ram[address];
    else if (is_stat)  rd_mux = DATA_W'(pack_uart_status(tx_busy, fifo_full, fifo_empty,
                                                         ovf, 4'(fifo_count)));
    else if (is_led)   rd_mux = DATA_W'(led);
    else if (is_cycle) rd_mux = cycle;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rdata <= '0;
      led   <= '0;
      cycle <= '0;
      ovf   <= 1'b0;
    end else begin
      cycle <= cycle + 1'b1;
      if (rd_en)                  rdata <= rd_mux;
      if (wr_en && is_led)        led   <= wdata[7:0];
      if (fifo_push && fifo_full) ovf   <= 1'b1;
      else if (rd_en && is_stat)  ovf   <= 1'b0;
    end
  end

endmodule

// File: tb/tb_mem_bus_ctrl.sv
// Directed bench for mem_bus_ctrl with CLKS_PER_BIT=4 and an 8-entry FIFO.
module tb_mem_bus_ctrl;

  logic        clk = 1'b0;
  logic        rst, write, read;
  logic [7:0]  address;
  logic [31:0] wdata, rdata;
  logic [7:0]  led;
  logic        uart_tx;

  int vectors     = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  mem_bus_ctrl #(
    .ADDR_W       (8),
    .DATA_W       (32),
    .CLKS_PER_BIT (4),
    .FIFO_DEPTH   (8)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .write   (write),
    .read    (read),
    .address (address),
    .wdata   (wdata),
    .rdata   (rdata),
    .led     (led),
    .uart_tx (uart_tx)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp)
    else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Line level p cycles into a frame of byte b (p=0 is the first start-bit cycle).
  function automatic logic frame_bit(input logic [7:0] b, input int p);
    if (p < 4)  return 1'b0;
    if (p < 36) return b[(p - 4) / 4];
    return 1'b1;
  endfunction

  // Overflow burst: frame j of byte 0x30+j starts at edge 2+41*j, nine frames total.
  function automatic logic burst_bit(input int t);
    int rel, j, p;
    logic [7:0] b;
    rel = t - 2;
    if (rel < 0) return 1'b1;
    j = rel / 41;
    p = rel % 41;
    if (j >= 9) return 1'b1;
    b = 8'h30 + 8'(j);
    return frame_bit(b, p);
  endfunction

  initial begin
    rst = 1'b1; write = 1'b0; read = 1'b0; address = '0; wdata = '0;
    repeat (3) @(negedge clk);
    check("rst_rdata", rdata, 32'h0);
    check("rst_led", {24'h0, led}, 32'h0);
    check("rst_tx", {31'h0, uart_tx}, 32'h1);

    rst = 1'b0; read = 1'b1; address = 8'hF3;
    @(negedge clk); check("cycle_0", rdata, 32'h0);
    @(negedge clk); check("cycle_1", rdata, 32'h1);
    address = 8'hF1;
    @(negedge clk); check("stat_reset", rdata, 32'h4);
    read = 1'b0;

    // RAM round trip, read on the cycle right after the write
    write = 1'b1; address = 8'h10; wdata = 32'h12345678;
    @(negedge clk);
    write = 1'b0; read = 1'b1;
    @(negedge clk); check("ram_rt", rdata, 32'h12345678);
    read = 1'b0;
    @(negedge clk); check("rdata_hold", rdata, 32'h12345678);
    write = 1'b1; address = 8'h00; wdata = 32'hDEADBEEF;
    @(negedge clk);
    address = 8'hEF; wdata = 32'hCAFEF00D;
    @(negedge clk);
    write = 1'b0; read = 1'b1; address = 8'h00;
    @(negedge clk); check("ram_lo", rdata, 32'hDEADBEEF);
    address = 8'hEF;
    @(negedge clk); check("ram_top", rdata, 32'hCAFEF00D);
    address = 8'h10;
    @(negedge clk); check("ram_10", rdata, 32'h12345678);

    // LED write with simultaneous read
    write = 1'b1; read = 1'b1; address = 8'hF2; wdata = 32'hAAAAAA3C;
    @(negedge clk);
    check("led_wr", {24'h0, led}, 32'h3C);
    check("wr_rd_rdata", rdata, 32'h12345678);
    write = 1'b0;
    @(negedge clk); check("led_rd", rdata, 32'h3C);

    // Reserved and write-only accesses
    read = 1'b0; write = 1'b1; address = 8'hF8; wdata = 32'hFFFFFFFF;
    @(negedge clk);
    write = 1'b0; read = 1'b1;
    @(negedge clk); check("rsv_rd", rdata, 32'h0);
    address = 8'hF2;
    @(negedge clk); check("rsv_led", rdata, 32'h3C);
    address = 8'hF0;
    @(negedge clk); check("wo_rd", rdata, 32'h0);
    address = 8'hF1;
    @(negedge clk); check("rsv_stat", rdata, 32'h4);
    check("rsv_led_port", {24'h0, led}, 32'h3C);
    read = 1'b0;

    // Single frame of 0xA5 with status polled throughout
    write = 1'b1; address = 8'hF0; wdata = 32'h000000A5;
    @(negedge clk);
    write = 1'b0;
    check("a5_pre", {31'h0, uart_tx}, 32'h1);
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      check($sformatf("a5_tx%0d", k), {31'h0, uart_tx}, {31'h0, frame_bit(8'hA5, k)});
      if (k >= 1) check($sformatf("a5_busy%0d", k), rdata, 32'h5);
      read = 1'b1; address = 8'hF1;
    end
    @(negedge clk);
    check("a5_busy_end", rdata, 32'h5);
    check("a5_idle", {31'h0, uart_tx}, 32'h1);
    @(negedge clk);
    check("a5_done", rdata, 32'h4);
    read = 1'b0;

    // Overflow: ten back-to-back pushes, the tenth is dropped
    for (int i = 0; i < 10; i++) begin
      write = 1'b1; address = 8'hF0; wdata = 32'h30 + i;
      @(negedge clk);
    end
    write = 1'b0; read = 1'b1; address = 8'hF1;
    @(negedge clk); check("ovf_stat1", rdata, 32'h8B);
    @(negedge clk); check("ovf_stat2", rdata, 32'h83);
    read = 1'b0;
    for (int t = 13; t <= 431; t++) begin
      @(negedge clk);
      check($sformatf("burst_tx%0d", t), {31'h0, uart_tx}, {31'h0, burst_bit(t)});
    end
    read = 1'b1;
    @(negedge clk); check("ovf_drained", rdata, 32'h4);
    read = 1'b0;

    // Reset during DATA bit 3 of 0xF7 (bit 3 = 0)
    write = 1'b1; address = 8'hF0; wdata = 32'h000000F7;
    @(negedge clk);
    write = 1'b0;
    repeat (18) @(negedge clk);
    check("mid_bit3", {31'h0, uart_tx}, 32'h0);
    rst = 1'b1;
    @(negedge clk);
    check("mid_rst_tx", {31'h0, uart_tx}, 32'h1);
    check("mid_rst_rdata", rdata, 32'h0);
    rst = 1'b0; read = 1'b1; address = 8'hF3;
    @(negedge clk); check("mid_cycle0", rdata, 32'h0);
    address = 8'hF1;
    @(negedge clk); check("mid_stat", rdata, 32'h4);
    address = 8'hF3;
    @(negedge clk); check("mid_cycle2", rdata, 32'h2);
    address = 8'h10;
    @(negedge clk); check("mid_ram", rdata, 32'h12345678);
    read = 1'b0;
    for (int c = 0; c < 45; c++) begin
      @(negedge clk);
      check($sformatf("mid_quiet%0d", c), {31'h0, uart_tx}, 32'h1);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/mem_bus_ctrl.md
MEM_BUS_CTRL -- requirements
Module: mem_bus_ctrl

Interface
REQ-001 Parameters, one per line (name, default, meaning):
- ADDR_W, 8, address width; equals `MemAddrBus.
- DATA_W, 32, data width; equals `MemBusWidth.
- CLKS_PER_BIT, 868, UART clocks per bit; legal range is 2 or more.
- FIFO_DEPTH, 8, UART TX FIFO entries; must be a power of 2.

REQ-002 Ports, one per line (name, direction, width, meaning):
- clk, input, 1, clock.
- rst, input, 1, reset; synchronous, active-high.
- write, input, 1, CPU write request.
- read, input, 1, CPU read request.
- address, input, ADDR_W, word address.
- wdata, input, DATA_W, write data from the CPU dout port.
- rdata, output, DATA_W, read data to the CPU din port.
- led, output, 8, LED register.
- uart_tx, output, 1, serial line, 8N1, idle high.

Function
REQ-003 Address map SHALL be:
- 0x00-0xEF: RAM, 240 words x DATA_W.
- 0xF0: UART_DATA, write-only.
- 0xF1: UART_STATUS, read-only.
- 0xF2: LED, read/write, bits [7:0].
- 0xF3: CYCLE, read-only.
- 0xF4-0xFF: reserved.

REQ-004 A write SHALL be accepted on each clk edge where write=1; there is no stall and no backpressure.

REQ-005 A read SHALL be sampled on each clk edge where read=1. rdata SHALL update exactly one cycle later and hold until the next accepted read.

REQ-006 If write and read are both 1 in the same cycle, the write SHALL be performed and the read ignored; rdata is unchanged.

REQ-007 RAM read-after-write to the same address on consecutive cycles SHALL return the newly written data.

REQ-008 Writing UART_DATA SHALL push wdata[7:0] into the TX FIFO.

REQ-009 A push to a full FIFO SHALL be dropped and SHALL set sticky bit ovf.

REQ-010 UART_STATUS read value SHALL be:
- bit0 tx_busy
- bit1 fifo_full
- bit2 fifo_empty
- bit3 ovf
- bits[7:4] fifo_count
- all other bits 0

A read of UART_STATUS SHALL clear ovf in the same edge. If a push overflow occurs in that same cycle, ovf SHALL remain set.

REQ-011 CYCLE SHALL be a free-running DATA_W counter that increments every cycle and wraps from all-ones to 0.

REQ-012 Writes to read-only or reserved addresses SHALL be ignored. Reads of reserved or write-only addresses SHALL return 0.

REQ-013 The UART FSM SHALL have states IDLE, START, DATA, STOP:
- IDLE: tx=1. When the FIFO is non-empty, pop one byte and go to START.
- START: tx=0 for CLKS_PER_BIT cycles.
- DATA: tx = data bit, LSB first, 8 bits, each held CLKS_PER_BIT cycles.
- STOP: tx=1 for CLKS_PER_BIT cycles, then return to IDLE.
- tx_busy = (state != IDLE).

REQ-014 When a push and a pop occur in the same cycle, fifo_count SHALL be unchanged. A push to a full FIFO SHALL still be dropped even if a pop occurs in the same cycle.

REQ-015 FIFO pointers SHALL wrap modulo FIFO_DEPTH. fifo_count SHALL range from 0 to FIFO_DEPTH.

Reset
REQ-016 While rst=1, the following SHALL hold on each clk edge:
- rdata=0, led=0, uart_tx=1.
- UART FSM in IDLE.
- FIFO emptied, ovf=0, CYCLE=0.
- Bit and baud counters cleared.
- CPU requests ignored.

REQ-017 Reset asserted mid-frame SHALL abort the frame and drive uart_tx=1 on the next edge.

REQ-018 RAM contents SHALL NOT be cleared by reset.

Structure
REQ-019 The following constants SHALL live in the shared ArchDef include:
- address-map constants: RAM_TOP, UART_DATA_ADDR, UART_STAT_ADDR, LED_ADDR, CYCLE_ADDR;
- UART state encodings.

REQ-020 The UART SHALL be a single sub-module uart_tx_fifo (FIFO plus TX FSM). It exposes push, push data, full, empty, count and busy.

REQ-021 RAM decode, LED, CYCLE and the read mux SHALL stay in mem_bus_ctrl.

Verification
REQ-022 The bench SHALL cover these directed scenarios, with CLKS_PER_BIT=4:
- RAM round trip: write 0x12345678 to 0x10, read 0x10 -> rdata=0x12345678 one cycle after the read.
- UART frame: write 0x000000A5 to 0xF0 -> uart_tx shows 0 (4 clk), bits 1,0,1,0,0,1,0,1 (4 clk each), 1 (4 clk); tx_busy=1 throughout, 0 afterwards.
- Overflow: 10 back-to-back writes to 0xF0 -> status reads full=1, ovf=1, count=8. A second status read gives ovf=0. Exactly 9 bytes are transmitted (1 popped immediately, plus 8 in the FIFO).
- LED and simultaneous access: write 0x3C to 0xF2 with read=1 on the same cycle -> led=0x3C and rdata unchanged. A later read of 0xF2 returns 0x3C.
- Reset mid-frame: assert rst during DATA bit 3 -> next edge uart_tx=1, status=0x04, CYCLE=0; RAM contents at 0x10 are preserved.
- Reserved access: write to 0xF8, then read 0xF8 and 0xF0 -> both return 0, with no side effects.
